// File: rtl/divider_8bit.sv
// 8-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// Optional divide-by-zero flag port DZ enabled by macro DIVIDER_8BIT_DZ_EN.
module divider_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       busy,
`ifdef DIVIDER_8BIT_DZ_EN
    output logic       DZ,
`endif
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    // dividend bits shift out of the top while quotient bits shift in below
    logic [7:0] dvd_q, dvd_d;
    logic [7:0] dvs_q, dvs_d;
    logic [7:0] rem_q, rem_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] q_q, q_d;
    logic [7:0] r_q, r_d;
`ifdef DIVIDER_8BIT_DZ_EN
    logic       dz_q, dz_d;
`endif

    logic [8:0] trial;
    logic [7:0] rem_nx;
    logic [7:0] dvd_nx;

    // One restoring step: trial subtract, keep or restore, emit quotient bit.
    // The partial remainder never exceeds 7 bits before a shift, so bit 7 is dropped.
    always_comb begin
        trial = {1'b0, rem_q[6:0], dvd_q[7]} - {1'b0, dvs_q};
        if (trial[8]) begin
            rem_nx = {rem_q[6:0], dvd_q[7]};
        end else begin
            rem_nx = trial[7:0];
        end
        dvd_nx = {dvd_q[6:0], ~trial[8]};
    end

    // Next-state and datapath control for IDLE/RUN/DONE.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DIVIDER_8BIT_DZ_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d   = A;
                    dvs_d   = B;
                    rem_d   = 8'd0;
                    cnt_d   = 3'd0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                dvd_d = dvd_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                    q_d     = dvd_nx;
                    r_d     = rem_nx;
`ifdef DIVIDER_8BIT_DZ_EN
                    dz_d    = (dvs_q == 8'd0);
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over everything, abandoning any division.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= 8'd0;
            dvs_q   <= 8'd0;
            rem_q   <= 8'd0;
            cnt_q   <= 3'd0;
            q_q     <= 8'd0;
            r_q     <= 8'd0;
`ifdef DIVIDER_8BIT_DZ_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
`ifdef DIVIDER_8BIT_DZ_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
`ifdef DIVIDER_8BIT_DZ_EN
    assign DZ   = dz_q;
`endif

endmodule

// File: doc/divider_8bit.md
DIVIDER_8BIT -- requirements
Module: divider_8bit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: ports clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a division; sampled on clk rising edge.
REQ-005 A  input  8  unsigned dividend; sampled with start.
REQ-006 B  input  8  unsigned divisor; sampled with start.
REQ-007 Q  output  8  unsigned quotient, registered.
REQ-008 R  output  8  unsigned remainder, registered.
REQ-009 busy  output  1  high while an iteration sequence runs.
REQ-010 done  output  1  one-cycle pulse; Q/R valid and new.
REQ-011 DZ  output  1  divide-by-zero flag; present only with DIVIDER_8BIT_DZ_EN (REQ-030).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE or DONE with start=1 at edge N: latch A and B, clear the iteration count, go to RUN.
REQ-014 The divider SHALL be restoring, one quotient bit per cycle, MSB first: 9-bit trial = {partial remainder[6:0], next dividend bit} - {1'b0, B}; nonnegative -> keep difference, bit=1; negative -> restore, bit=0.
REQ-015 RUN SHALL take exactly 8 cycles (edges N+1..N+8); at edge N+8 go to DONE and load Q and R.
REQ-016 done SHALL be 1 only in DONE (the cycle after edge N+8); latency start-edge to done = 9 cycles.
REQ-017 DONE with start=0 SHALL return to IDLE at the next edge.
REQ-018 DONE with start=1 SHALL accept the new operands (back-to-back, no idle gap).
REQ-019 busy SHALL be 1 exactly in RUN; 0 in IDLE and DONE.
REQ-020 start in RUN SHALL be ignored; operands in flight unchanged; no queueing.
REQ-021 Q and R SHALL hold their last value from DONE until the next load; they do not change during RUN.
REQ-022 B=0 SHALL follow REQ-014 unchanged: Q=8'hFF, R=A.
REQ-023 Result identity: A == Q*B + R and R < B for every B != 0.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, Q=0, R=0, busy=0, done=0, DZ=0.
REQ-025 rst SHALL take priority over start and over every state, including mid-RUN; the in-flight division is abandoned and produces no done.
REQ-026 The first edge with rst=0 and start=1 SHALL start a division normally.
REQ-027 Internal operand, partial-remainder and iteration-count registers SHALL reset to 0.

Configuration
REQ-028 The macro SHALL be DIVIDER_8BIT_DZ_EN.
REQ-029 Without the macro: no DZ port; B=0 yields REQ-022 results silently.
REQ-030 With the macro: port DZ, registered, loaded with (latched B == 0) at the DONE transition, held like Q/R; Q/R still per REQ-022; latency unchanged.

Verification
REQ-031 Basic: A=200, B=7, start pulse -> busy 8 cycles, done on 9th cycle, Q=28, R=4.
REQ-032 Extremes: A=255,B=1 -> Q=255,R=0; A=5,B=9 -> Q=0,R=5; A=0,B=3 -> Q=0,R=0.
REQ-033 Divide by zero: A=100, B=0 -> Q=8'hFF, R=100; with DIVIDER_8BIT_DZ_EN DZ=1, next op A=9,B=3 -> Q=3,R=0,DZ=0.
REQ-034 Busy ignore: start A=50,B=5, then start A=9,B=2 during RUN cycle 3 -> exactly one done, Q=10,R=0.
REQ-035 Reset mid-op: start A=77,B=3, rst at RUN cycle 4 -> no done, Q=0,R=0,busy=0; then A=77,B=3 -> Q=25,R=2.
REQ-036 Back-to-back: start held through DONE with A=13,B=4 then A=240,B=16 -> done pulses 9 cycles apart, Q/R = 3/1 then 15/0.
